// File: rtl/pc_pkg.sv
// pc_pkg: shared types and default vectors for the program-counter sequencer.
// Sequencer states and redirect kinds are encoded here so the arbiter and the
// top agree on redirect priority (a larger redir_t value means higher priority).
package pc_pkg;

    localparam int          PC_WIDTH_DEF  = 16;
    localparam logic [15:0] RESET_VEC_DEF = 16'h0000;
    localparam logic [15:0] TRAP_VEC_DEF  = 16'h0004;
    localparam int          PC_INC_DEF    = 2;

    typedef enum logic [1:0] {
        PC_BOOT = 2'd0,
        PC_RUN  = 2'd1,
        PC_HALT = 2'd2
    } pc_state_t;

    // Numeric order is the priority order: TRAP > JUMP > BRANCH > NONE
    typedef enum logic [1:0] {
        REDIR_NONE   = 2'd0,
        REDIR_BRANCH = 2'd1,
        REDIR_JUMP   = 2'd2,
        REDIR_TRAP   = 2'd3
    } redir_t;

    // True when a live redirect may replace the buffered one
    function automatic logic redir_wins(input redir_t live, input redir_t pend);
        return (live != REDIR_NONE) && (live >= pend);
    endfunction

endpackage

// File: rtl/pc_redirect_arb.sv
// pc_redirect_arb: combinational priority select between the live redirect
// sources (trap > jump > branch) and the buffered pending redirect.
// A live request of equal or higher priority than the pending one wins.
module pc_redirect_arb
    import pc_pkg::*;
#(
    parameter int               WIDTH    = PC_WIDTH_DEF,
    parameter logic [WIDTH-1:0] TRAP_VEC = WIDTH'(TRAP_VEC_DEF)
) (
    input  logic             trap,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  redir_t           pend_kind,
    input  logic [WIDTH-1:0] pend_target,
    output redir_t           live_kind,
    output logic [WIDTH-1:0] live_target,
    output redir_t           win_kind,
    output logic [WIDTH-1:0] win_target
);

    // Highest-priority live redirect this cycle
    always_comb begin
        live_kind   = REDIR_NONE;
        live_target = {WIDTH{1'b0}};
        if (trap) begin
            live_kind   = REDIR_TRAP;
            live_target = TRAP_VEC;
        end else if (jump) begin
            live_kind   = REDIR_JUMP;
            live_target = jump_target;
        end else if (branch_taken) begin
            live_kind   = REDIR_BRANCH;
            live_target = branch_target;
        end else begin
            live_kind   = REDIR_NONE;
            live_target = {WIDTH{1'b0}};
        end
    end

    // Live request beats pending when its priority is at least as high
    always_comb begin
        win_kind   = pend_kind;
        win_target = pend_target;
        if (redir_wins(live_kind, pend_kind)) begin
            win_kind   = live_kind;
            win_target = live_target;
        end else begin
            win_kind   = pend_kind;
            win_target = pend_target;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the fetch PC, selects the next PC (sequential, branch,
// jump, trap), buffers redirects that arrive while the PC cannot advance and
// drives the instruction-fetch request.
// Optional build macro PC_ALIGN_CHECK_EN: odd branch/jump/pending targets are
// rejected, the PC is sent to TRAP_VEC and misalign pulses for one cycle.
// Without the macro targets load verbatim and misalign stays 0.
// Redirects seen during the single BOOT cycle are ignored.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int               WIDTH     = PC_WIDTH_DEF,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(RESET_VEC_DEF),
    parameter logic [WIDTH-1:0] TRAP_VEC  = WIDTH'(TRAP_VEC_DEF),
    parameter int               INC       = PC_INC_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             imem_ready,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             trap,
    input  logic             halt_req,
    input  logic             resume,
    output logic [WIDTH-1:0] PC_out,
    output logic [WIDTH-1:0] PC_Add_out,
    output logic             imem_req,
    output logic [1:0]       pc_state,
    output logic             misalign
);

    pc_state_t        state_r;
    pc_state_t        state_next_s;
    logic [WIDTH-1:0] pc_r;
    logic [WIDTH-1:0] pc_next_s;
    redir_t           pend_kind_r;
    redir_t           pend_kind_next_s;
    logic [WIDTH-1:0] pend_target_r;
    logic [WIDTH-1:0] pend_target_next_s;
    logic             imem_req_r;
    logic             misalign_r;
    logic             misalign_next_s;

    redir_t           live_kind_s;
    logic [WIDTH-1:0] live_target_s;
    redir_t           win_kind_s;
    logic [WIDTH-1:0] win_target_s;
    logic             adv_s;
    logic             capture_s;
    logic             align_bad_s;
    logic [WIDTH-1:0] pc_inc_s;

    pc_redirect_arb #(
        .WIDTH    (WIDTH),
        .TRAP_VEC (TRAP_VEC)
    ) u_arb (
        .trap          (trap),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pend_kind     (pend_kind_r),
        .pend_target   (pend_target_r),
        .live_kind     (live_kind_s),
        .live_target   (live_target_s),
        .win_kind      (win_kind_s),
        .win_target    (win_target_s)
    );

    assign adv_s     = (state_r == PC_RUN) && imem_ready && !stall;
    assign capture_s = redir_wins(live_kind_s, pend_kind_r);
    assign pc_inc_s  = pc_r + WIDTH'(INC);

`ifdef PC_ALIGN_CHECK_EN
    assign align_bad_s = win_target_s[0];
`else
    assign align_bad_s = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= PC_BOOT;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state selection: trap wakes from HALT and outranks halt_req
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            PC_BOOT: state_next_s = PC_RUN;
            PC_RUN: begin
                if (trap) begin
                    state_next_s = PC_RUN;
                end else if (halt_req) begin
                    state_next_s = PC_HALT;
                end else begin
                    state_next_s = PC_RUN;
                end
            end
            PC_HALT: begin
                if (trap || resume) begin
                    state_next_s = PC_RUN;
                end else begin
                    state_next_s = PC_HALT;
                end
            end
            default: state_next_s = PC_BOOT;
        endcase
    end

    // Next PC, pending buffer and misalign pulse for the coming edge
    always_comb begin
        pc_next_s          = pc_r;
        pend_kind_next_s   = pend_kind_r;
        pend_target_next_s = pend_target_r;
        misalign_next_s    = 1'b0;
        case (state_r)
            PC_RUN: begin
                if (trap) begin
                    pc_next_s          = TRAP_VEC;
                    pend_kind_next_s   = REDIR_NONE;
                    pend_target_next_s = {WIDTH{1'b0}};
                end else if (!halt_req && adv_s) begin
                    if (win_kind_s == REDIR_NONE) begin
                        pc_next_s = pc_inc_s;
                    end else if (align_bad_s) begin
                        pc_next_s       = TRAP_VEC;
                        misalign_next_s = 1'b1;
                    end else begin
                        pc_next_s = win_target_s;
                    end
                    pend_kind_next_s   = REDIR_NONE;
                    pend_target_next_s = {WIDTH{1'b0}};
                end else if (capture_s) begin
                    pend_kind_next_s   = live_kind_s;
                    pend_target_next_s = live_target_s;
                end else begin
                    pc_next_s = pc_r;
                end
            end
            PC_HALT: begin
                if (trap) begin
                    pc_next_s          = TRAP_VEC;
                    pend_kind_next_s   = REDIR_NONE;
                    pend_target_next_s = {WIDTH{1'b0}};
                end else if (capture_s) begin
                    pend_kind_next_s   = live_kind_s;
                    pend_target_next_s = live_target_s;
                end else begin
                    pc_next_s = pc_r;
                end
            end
            default: begin
                pc_next_s = pc_r;
            end
        endcase
    end

    // Datapath registers: PC, pending redirect, fetch request, misalign pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r          <= RESET_VEC;
            pend_kind_r   <= REDIR_NONE;
            pend_target_r <= {WIDTH{1'b0}};
            imem_req_r    <= 1'b0;
            misalign_r    <= 1'b0;
        end else begin
            pc_r          <= pc_next_s;
            pend_kind_r   <= pend_kind_next_s;
            pend_target_r <= pend_target_next_s;
            imem_req_r    <= (state_next_s == PC_RUN);
            misalign_r    <= misalign_next_s;
        end
    end

    // Output mapping; PC_Add_out is the live incrementer value
    always_comb begin
        PC_out     = pc_r;
        PC_Add_out = pc_inc_s;
        imem_req   = imem_req_r;
        pc_state   = state_r;
        misalign   = misalign_r;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scenarios followed by randomized traffic, all
// checked against a behavioural model of the PC sequencing rules.
module tb_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        imem_ready;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        jump;
    logic [15:0] jump_target;
    logic        trap;
    logic        halt_req;
    logic        resume;
    logic [15:0] PC_out;
    logic [15:0] PC_Add_out;
    logic        imem_req;
    logic [1:0]  pc_state;
    logic        misalign;

    int checks = 0;
    int errors = 0;

`ifdef PC_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    // Model state: mode 0=BOOT 1=RUN 2=HALT; pending priority 0=none 1=branch 2=jump
    int          m_mode;
    logic [15:0] m_pc;
    int          m_pend_prio;
    logic [15:0] m_pend_tgt;
    bit          m_mis;

    pc_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .imem_ready    (imem_ready),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .trap          (trap),
        .halt_req      (halt_req),
        .resume        (resume),
        .PC_out        (PC_out),
        .PC_Add_out    (PC_Add_out),
        .imem_req      (imem_req),
        .pc_state      (pc_state),
        .misalign      (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode      = 0;
        m_pc        = 16'h0000;
        m_pend_prio = 0;
        m_pend_tgt  = 16'h0000;
        m_mis       = 1'b0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".pc"},   PC_out,     m_pc);
        chk({tag, ".add"},  PC_Add_out, 16'(m_pc + 16'd2));
        chk({tag, ".req"},  {15'd0, imem_req}, {15'd0, (m_mode == 1)});
        chk({tag, ".st"},   {14'd0, pc_state}, 16'(m_mode));
        chk({tag, ".mis"},  {15'd0, misalign}, {15'd0, m_mis});
    endtask

    task automatic idle_inputs();
        stall = 1'b0; imem_ready = 1'b1; branch_taken = 1'b0; branch_target = 16'h0000;
        jump = 1'b0; jump_target = 16'h0000; trap = 1'b0; halt_req = 1'b0; resume = 1'b0;
    endtask

    // Apply the sequencing rules to the current inputs, then clock and compare
    task automatic tick(input string tag);
        int          live_prio;
        logic [15:0] live_tgt;
        int          nmode;
        bit          adv;
        logic [15:0] tgt;
        live_prio = jump ? 2 : (branch_taken ? 1 : 0);
        live_tgt  = jump ? jump_target : branch_target;
        adv       = (m_mode == 1) && imem_ready && !stall;
        nmode     = m_mode;
        m_mis     = 1'b0;
        if (m_mode == 0) begin
            nmode = 1;
        end else if (trap) begin
            m_pc = 16'h0004; m_pend_prio = 0; nmode = 1;
        end else if (m_mode == 1 && !halt_req && adv) begin
            if (live_prio > 0 && live_prio >= m_pend_prio) tgt = live_tgt;
            else tgt = m_pend_tgt;
            if (live_prio == 0 && m_pend_prio == 0) m_pc = m_pc + 16'd2;
            else if (ALIGN_CHK && tgt[0]) begin m_pc = 16'h0004; m_mis = 1'b1; end
            else m_pc = tgt;
            m_pend_prio = 0;
        end else begin
            if (live_prio > 0 && live_prio >= m_pend_prio) begin
                m_pend_prio = live_prio; m_pend_tgt = live_tgt;
            end
            if (m_mode == 1 && halt_req) nmode = 2;
            if (m_mode == 2 && resume) nmode = 1;
        end
        m_mode = nmode;
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        #12;
        check_model("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // 1: boot then sequential fetch
        tick("boot");
        chk("boot_pc0", PC_out, 16'h0000);
        tick("seq1");
        chk("seq_pc2", PC_out, 16'h0002);
        tick("seq2");
        chk("seq_pc4", PC_out, 16'h0004);

        // 2: wrap-around of the incrementer
        jump = 1'b1; jump_target = 16'hFFFE;
        tick("jmp_fffe");
        chk("fffe_add", PC_Add_out, 16'h0000);
        jump = 1'b0;
        tick("wrap0");
        chk("wrap_pc0", PC_out, 16'h0000);
        jump = 1'b1; jump_target = 16'hFFFF;
        tick("jmp_ffff");
        jump = 1'b0;
        tick("wrap1");
        if (!ALIGN_CHK) chk("wrap_pc1", PC_out, 16'h0001);

        // 3: branch buffered during stall
        jump = 1'b1; jump_target = 16'h0010;
        tick("to_0010");
        jump = 1'b0; stall = 1'b1; branch_taken = 1'b1; branch_target = 16'h0100;
        tick("stall_br");
        branch_taken = 1'b0;
        for (int i = 0; i < 3; i++) tick("stall_hold");
        chk("stall_pc", PC_out, 16'h0010);
        stall = 1'b0;
        tick("stall_rel");
        chk("pend_br", PC_out, 16'h0100);

        // 4: branch+jump stalled, then trap overrides without waiting
        stall = 1'b1; branch_taken = 1'b1; branch_target = 16'h0200;
        jump = 1'b1; jump_target = 16'h0300;
        tick("bj_stall");
        branch_taken = 1'b0; jump = 1'b0; trap = 1'b1;
        tick("trap_stall");
        chk("trap_pc", PC_out, 16'h0004);
        trap = 1'b0; stall = 1'b0;
        tick("post_trap");
        chk("trap_clr", PC_out, 16'h0006);

        // 5: halt, jump while halted, resume
        jump = 1'b1; jump_target = 16'h0020;
        tick("to_0020");
        jump = 1'b0; halt_req = 1'b1;
        tick("halt");
        chk("halt_req0", {15'd0, imem_req}, 16'h0000);
        halt_req = 1'b0; jump = 1'b1; jump_target = 16'h0400;
        tick("halt_jmp");
        jump = 1'b0; resume = 1'b1;
        tick("resume");
        chk("resume_pc", PC_out, 16'h0020);
        resume = 1'b0;
        tick("resume_adv");
        chk("resume_jmp", PC_out, 16'h0400);

        // 6: odd target
        jump = 1'b1; jump_target = 16'h0101;
        tick("odd_jmp");
        chk("odd_pc", PC_out, ALIGN_CHK ? 16'h0004 : 16'h0101);
        jump = 1'b0;
        tick("odd_after");

        // reset pulse with a pending redirect
        stall = 1'b1; jump = 1'b1; jump_target = 16'h0500;
        tick("rst_pend");
        jump = 1'b0;
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_model("rst_mid");
        @(negedge clk);
        rst_n = 1'b1; stall = 1'b0;
        tick("rst_boot");
        tick("rst_seq");
        chk("rst_pend_gone", PC_out, 16'h0002);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            stall         = ($urandom_range(0, 3) == 0);
            imem_ready    = ($urandom_range(0, 3) != 0);
            branch_taken  = ($urandom_range(0, 9) == 0);
            branch_target = 16'($urandom);
            jump          = ($urandom_range(0, 11) == 0);
            jump_target   = 16'($urandom);
            trap          = ($urandom_range(0, 29) == 0);
            halt_req      = ($urandom_range(0, 24) == 0);
            resume        = ($urandom_range(0, 4) == 0);
            tick("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
